// File: rtl/lottery_pkg.sv
// Shared types and constants for the lottery pool: FSM states and LFSR setup.
package lottery_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SCAN,
    ST_ANNOUNCE,
    ST_DONE
  } state_e;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lottery_lfsr.sv
// Free-running Galois LFSR; shifts right every cycle and folds the taps in on a 1 out.
module lottery_lfsr
  import lottery_pkg::*;
#(
  parameter int              W    = LFSR_W,
  parameter logic [W-1:0]    TAPS = LFSR_TAPS,
  parameter logic [W-1:0]    SEED = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = {1'b0, state_q[W-1:1]} ^ (state_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lottery_pool.sv
// Lucky-bit pool: collects participants, then draws up to NUM_DRAWS distinct winners
// by wrap-around scans from LFSR-chosen start points, announced over valid/ready.
module lottery_pool
  import lottery_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter int          ID_W      = $clog2(DEPTH),
  parameter int          NUM_DRAWS = 1,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            luckybit,
  input  logic            write,
  input  logic            stop,
  input  logic            clear,
  input  logic            winner_ready,
  output logic [ID_W:0]   id,
  output logic            full,
  output logic            overflow,
  output logic [ID_W-1:0] winner,
  output logic            winner_valid,
  output logic            no_winner,
  output logic            draw_done
);

  localparam int              CNT_W   = ID_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DRAWS_C = CNT_W'(NUM_DRAWS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    id_q, id_d;
  logic [DEPTH-1:0]    pool_q, pool_d;
  logic                overflow_q, overflow_d;
  logic [ID_W-1:0]     winner_q, winner_d;
  logic                valid_q, valid_d;
  logic                no_winner_q, no_winner_d;
  logic                draw_done_q, draw_done_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    scanned_q, scanned_d;
  logic [CNT_W-1:0]    draws_q, draws_d;

  logic [LFSR_W-1:0]   lfsr_state;
  logic                lfsr_unused;
  logic [ID_W-1:0]     start_ptr;
  logic [CNT_W-1:0]    ptr_next;
  logic                is_full;

  lottery_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[LFSR_W-1:ID_W];
  // Out-of-range LFSR picks fall back to entry 0 rather than re-rolling.
  assign start_ptr   = (CNT_W'(lfsr_state[ID_W-1:0]) < id_q) ? lfsr_state[ID_W-1:0] : '0;
  assign ptr_next    = CNT_W'(ptr_q) + ONE_C;
  assign is_full     = (id_q == DEPTH_C);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    pool_d      = pool_q;
    overflow_d  = overflow_q;
    winner_d    = winner_q;
    valid_d     = valid_q;
    no_winner_d = no_winner_q;
    draw_done_d = draw_done_q;
    ptr_d       = ptr_q;
    scanned_d   = scanned_q;
    draws_d     = draws_q;

    case (state_q)
      ST_COLLECT: begin
        if (stop) begin
          if (id_q == '0) begin
            no_winner_d = 1'b1;
            draw_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ptr_d     = start_ptr;
            scanned_d = '0;
            state_d   = ST_SCAN;
          end
        end else if (write) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            pool_d[id_q[ID_W-1:0]] = luckybit;
            id_d                   = id_q + ONE_C;
          end
        end
      end
      ST_SCAN: begin
        if (pool_q[ptr_q]) begin
          winner_d = ptr_q;
          valid_d  = 1'b1;
          state_d  = ST_ANNOUNCE;
        end else if (scanned_q + ONE_C == id_q) begin
          no_winner_d = 1'b1;
          draw_done_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          ptr_d     = (ptr_next == id_q) ? '0 : ptr_next[ID_W-1:0];
          scanned_d = scanned_q + ONE_C;
        end
      end
      ST_ANNOUNCE: begin
        if (winner_ready) begin
          pool_d[winner_q] = 1'b0;
          valid_d          = 1'b0;
          draws_d          = draws_q + ONE_C;
          if (draws_q + ONE_C == DRAWS_C) begin
            draw_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ptr_d     = start_ptr;
            scanned_d = '0;
            state_d   = ST_SCAN;
          end
        end
      end
      default: ;
    endcase

    // The LFSR is deliberately left running so successive rounds differ.
    if (clear) begin
      state_d     = ST_COLLECT;
      id_d        = '0;
      pool_d      = '0;
      overflow_d  = 1'b0;
      valid_d     = 1'b0;
      no_winner_d = 1'b0;
      draw_done_d = 1'b0;
      draws_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_COLLECT;
      id_q        <= '0;
      pool_q      <= '0;
      overflow_q  <= 1'b0;
      winner_q    <= '0;
      valid_q     <= 1'b0;
      no_winner_q <= 1'b0;
      draw_done_q <= 1'b0;
      ptr_q       <= '0;
      scanned_q   <= '0;
      draws_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      pool_q      <= pool_d;
      overflow_q  <= overflow_d;
      winner_q    <= winner_d;
      valid_q     <= valid_d;
      no_winner_q <= no_winner_d;
      draw_done_q <= draw_done_d;
      ptr_q       <= ptr_d;
      scanned_q   <= scanned_d;
      draws_q     <= draws_d;
    end
  end

  assign id           = id_q;
  assign full         = is_full;
  assign overflow     = overflow_q;
  assign winner       = winner_q;
  assign winner_valid = valid_q;
  assign no_winner    = no_winner_q;
  assign draw_done    = draw_done_q;

endmodule

// File: tb/tb_lottery_pool.sv
// Directed bench for lottery_pool: single-draw and three-draw instances share stimulus;
// expected winners come from an independent LFSR/scan model through a scoreboard queue.
module tb_lottery_pool;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic luckybit = 1'b0, write = 1'b0, stop = 1'b0, clear = 1'b0, winner_ready = 1'b0;

  logic [5:0] id1, id3;
  logic [4:0] win1, win3;
  logic full1, ovf1, val1, now1, done1;
  logic full3, ovf3, val3, now3, done3;

  lottery_pool #(.NUM_DRAWS(1)) u_one (
    .clk(clk), .reset(reset), .luckybit(luckybit), .write(write), .stop(stop),
    .clear(clear), .winner_ready(winner_ready), .id(id1), .full(full1),
    .overflow(ovf1), .winner(win1), .winner_valid(val1), .no_winner(now1),
    .draw_done(done1)
  );

  lottery_pool #(.NUM_DRAWS(3)) u_three (
    .clk(clk), .reset(reset), .luckybit(luckybit), .write(write), .stop(stop),
    .clear(clear), .winner_ready(winner_ready), .id(id3), .full(full3),
    .overflow(ovf3), .winner(win3), .winner_valid(val3), .no_winner(now3),
    .draw_done(done3)
  );

  always #5 clk = ~clk;

  logic sel3 = 1'b0;
  wire [5:0] o_id    = sel3 ? id3   : id1;
  wire [4:0] o_win   = sel3 ? win3  : win1;
  wire       o_full  = sel3 ? full3 : full1;
  wire       o_ovf   = sel3 ? ovf3  : ovf1;
  wire       o_valid = sel3 ? val3  : val1;
  wire       o_now   = sel3 ? now3  : now1;
  wire       o_done  = sel3 ? done3 : done1;

  // Reference LFSR, reset and clocked alongside the DUTs.
  logic [15:0] m_lfsr = 16'hACE1;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  logic [31:0] m_pool = '0;
  int          m_id = 0;
  int          sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int exp_winner(logic [15:0] l, logic [31:0] pool, int n);
    int p;
    p = (int'(l[4:0]) < n) ? int'(l[4:0]) : 0;
    for (int k = 0; k < n; k++) begin
      if (pool[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic b);
    write = 1'b1; luckybit = b;
    @(negedge clk);
    write = 1'b0;
    if (m_id < 32) begin m_pool[m_id] = b; m_id++; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pool = '0; m_id = 0;
  endtask

  task automatic do_stop(input bit push);
    if (push) sb.push_back(exp_winner(m_lfsr, m_pool, m_id));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic fresh_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_pool = '0; m_id = 0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (o_valid === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic pop_chk(input string tag, output int w);
    int e;
    e = (sb.size() > 0) ? sb.pop_front() : -2;
    w = e;
    chk(tag, 32'(o_win), 32'(e));
  endtask

  int w, wa, e;

  initial begin
    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_id", 32'(o_id), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    chk("rst_win", 32'(o_win), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_now", 32'(o_now), 0);
    chk("rst_done", 32'(o_done), 0);
    @(negedge clk);
    reset = 1'b1;

    // Fill to capacity, then overflow
    for (int i = 0; i < 32; i++) wr(1'b1);
    chk("fill_id", 32'(o_id), 32);
    chk("fill_full", 32'(o_full), 1);
    chk("fill_ovf", 32'(o_ovf), 0);
    wr(1'b1);
    chk("ovf_id", 32'(o_id), 32);
    chk("ovf_set", 32'(o_ovf), 1);
    do_clear();
    chk("clr_id", 32'(o_id), 0);
    chk("clr_ovf", 32'(o_ovf), 0);
    chk("clr_full", 32'(o_full), 0);

    // Single eligible entry 5 among 8, single-draw instance
    for (int i = 0; i < 8; i++) wr(i == 5);
    winner_ready = 1'b1;
    do_stop(1);
    wait_valid("one_valid");
    pop_chk("one_winner", w);
    chk("one_is5", 32'(o_win), 5);
    @(negedge clk);
    chk("one_valid_drop", 32'(o_valid), 0);
    chk("one_done", 32'(o_done), 1);
    chk("one_now", 32'(o_now), 0);
    repeat (3) @(negedge clk);
    chk("one_no_second", 32'(o_valid), 0);
    winner_ready = 1'b0;
    do_clear();

    // All-zero pool: miss reported exactly 8 edges after stop
    for (int i = 0; i < 8; i++) wr(1'b0);
    do_stop(0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("miss_valid", 32'(o_valid), 0);
      chk("miss_done", 32'(o_done), (k == 8) ? 1 : 0);
      chk("miss_now", 32'(o_now), (k == 8) ? 1 : 0);
    end
    do_clear();

    // Three draws from {2,9,17} among 20, 4-cycle stall per winner
    sel3 = 1'b1;
    for (int i = 0; i < 20; i++) wr(i == 2 || i == 9 || i == 17);
    do_stop(1);
    for (int d = 0; d < 3; d++) begin
      wait_valid("multi_valid");
      pop_chk("multi_winner", e);
      w = int'(o_win);
      chk("multi_in_set", 32'(w == 2 || w == 9 || w == 17), 1);
      repeat (4) begin
        @(negedge clk);
        chk("multi_stable", 32'(o_win), 32'(w));
        chk("multi_hold", 32'(o_valid), 1);
      end
      if (e >= 0) m_pool[e] = 1'b0;
      if (d < 2) sb.push_back(exp_winner(m_lfsr, m_pool, m_id));
      winner_ready = 1'b1;
      @(negedge clk);
      winner_ready = 1'b0;
      chk("multi_hs_drop", 32'(o_valid), 0);
    end
    chk("multi_done", 32'(o_done), 1);
    chk("multi_now", 32'(o_now), 0);
    sel3 = 1'b0;
    do_clear();

    // stop beats a same-cycle write; clear during ANNOUNCE
    for (int i = 0; i < 3; i++) wr(1'b1);
    write = 1'b1; luckybit = 1'b1; stop = 1'b1;
    @(negedge clk);
    write = 1'b0; stop = 1'b0;
    chk("ws_id", 32'(o_id), 3);
    chk("ws_ovf", 32'(o_ovf), 0);
    wait_valid("ann_valid");
    do_clear();
    chk("ann_clr_id", 32'(o_id), 0);
    chk("ann_clr_valid", 32'(o_valid), 0);
    chk("ann_clr_done", 32'(o_done), 0);
    wr(1'b1);
    chk("ann_collect", 32'(o_id), 1);

    // Reference round, aborted round, then replay after reset
    winner_ready = 1'b1;
    fresh_reset();
    for (int i = 0; i < 20; i++) wr(i == 3 || i == 11);
    do_stop(1);
    wait_valid("rep_a_valid");
    pop_chk("rep_a_winner", e);
    wa = int'(o_win);

    fresh_reset();
    for (int i = 0; i < 20; i++) wr(i == 3 || i == 11);
    do_stop(0);
    reset = 1'b0;
    #1;
    chk("abort_id", 32'(o_id), 0);
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_done", 32'(o_done), 0);
    chk("abort_win", 32'(o_win), 0);
    @(negedge clk);

    fresh_reset();
    for (int i = 0; i < 20; i++) wr(i == 3 || i == 11);
    do_stop(1);
    wait_valid("rep_b_valid");
    pop_chk("rep_b_winner", e);
    chk("rep_same", 32'(o_win), 32'(wa));
    winner_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lottery_pool.md
# lottery_pool

Parametrised successor of the 32-entry single-draw lottery. Collects one lucky bit per registered participant. On `stop`, it draws up to NUM_DRAWS distinct winners among participants whose bit is 1. Each draw starts at an LFSR-chosen index and scans with wrap-around. Winners are presented over a valid/ready handshake, and the pool can be cleared for a new round without reset.

## Interface
- DEPTH, 32: maximum participants; power of two, at least 4.
- ID_W, $clog2(DEPTH): width of `winner`.
- NUM_DRAWS, 1: winners drawn per round, 1..DEPTH.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- luckybit  in  1  participant's bit, sampled with `write`.
- write  in  1  append `luckybit` as the next participant.
- stop  in  1  close registration and start drawing.
- clear  in  1  synchronous; empty the pool and return to COLLECT.
- winner_ready  in  1  consumer accepts the current winner.
- id  out  ID_W+1  number of registered participants; the next id to be assigned.
- full  out  1  `id == DEPTH`.
- overflow  out  1  sticky; a write was dropped while full.
- winner  out  ID_W  index of the drawn participant.
- winner_valid  out  1  `winner` is valid.
- no_winner  out  1  a draw found no eligible entry.
- draw_done  out  1  round finished.

## Operation
- States: COLLECT, SCAN, ANNOUNCE, DONE. Reset state is COLLECT.
- Reset values:
  - `id`, `winner` = 0.
  - `full`, `overflow`, `winner_valid`, `no_winner`, `draw_done` = 0.
  - Pool bits = 0; LFSR = SEED; draw count = 0.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle in every state; frozen only in reset.
- COLLECT:
  - `write` with `full` = 0: `pool[id] <= luckybit`, `id <= id + 1`.
  - `write` with `full` = 1: entry dropped, `overflow <= 1`.
- `stop` in COLLECT wins over a same-cycle `write`; that write is dropped and does not set `overflow`.
- `stop` with `id` == 0: go to DONE with `no_winner` = 1 and `draw_done` = 1.
- Otherwise on `stop`: go to SCAN with the start pointer `ptr` and `scanned` = 0.
  - `ptr = lfsr[ID_W-1:0]` if that value is less than `id`, else 0.
- SCAN, one entry per cycle:
  - `pool[ptr]` = 1: `winner <= ptr`, `winner_valid <= 1`, go to ANNOUNCE.
  - Else: `ptr <= (ptr + 1 == id) ? 0 : ptr + 1`, `scanned <= scanned + 1`.
  - `scanned + 1 == id` with no hit: `no_winner <= 1`, `draw_done <= 1`, go to DONE.
- ANNOUNCE:
  - `winner` and `winner_valid` hold stable until `winner_ready` is 1.
  - On handshake: `pool[winner] <= 0` (draw without replacement), `winner_valid <= 0`, draw count + 1.
  - Draw count reaches NUM_DRAWS: `draw_done <= 1`, go to DONE.
  - Otherwise: go to SCAN with a new start pointer, computed by the same rule from the current LFSR value.
- DONE: outputs hold. `write` and `stop` are ignored.
- `clear` in any state: back to COLLECT.
  - Resets `id`, pool, flags, `winner_valid` and draw count.
  - Does not reset the LFSR.
  - Has priority over every other input.
- `write` outside COLLECT is ignored and does not set `overflow`.
- Reset asserted mid-round aborts immediately; all outputs return to their reset values.

## Timing
- `id` and `full` update on the edge that samples `write`.
- The first SCAN cycle is the cycle after the `stop` edge.
- Hit on the k-th scanned entry (k = 1..id): `winner_valid` is high k edges after the `stop` edge.
- The worst-case miss reaches DONE `id` edges after `stop`.
- Handshake edge: `winner_valid` is low in the next cycle.
- The next draw's SCAN begins in the cycle after the handshake.
- `winner_ready` held high continuously still costs one ANNOUNCE cycle per winner.
- No combinational path from any input to any output.

## Structure
- `lottery_pkg` contains:
  - the state enum;
  - LFSR width (16) and taps (16'hB400);
  - the default SEED.
- Sub-module `lottery_lfsr`: parametrised Galois LFSR with a 16-bit `state` output.
- Pool, counters and FSM live in `lottery_pool`.

## Test plan
- 32 writes with `luckybit` = 1, then a 33rd write: `full` = 1, `id` = 32, `overflow` = 1.
- 8 writes with only entry 5 set, then `stop`, `winner_ready` = 1: exactly one winner, `winner` = 5, `draw_done` = 1, `no_winner` = 0, for any SEED.
- 8 writes all 0, then `stop`: `no_winner` = 1 and `draw_done` = 1 exactly 8 edges after `stop`; `winner_valid` never asserts.
- NUM_DRAWS = 3, entries 2, 9 and 17 set among 20 writes, `winner_ready` stalled 4 cycles per winner:
  - three distinct winners from {2, 9, 17}, matching the reference model driven by the same LFSR;
  - `winner` stays stable during each stall.
- `write` and `stop` in the same cycle with `id` = 3: `id` stays 3. Assert `clear` during ANNOUNCE: next cycle COLLECT, `id` = 0, `winner_valid` = 0.
- Assert reset (low) during SCAN: all outputs return to their reset values immediately. After release, the LFSR restarts from 16'hACE1 and a repeat round reproduces the same winner.
